// File: rtl/rx_link_framer.sv
// rx_link_framer: link synchronisation and frame delimiting for the decoded
// 8B/10B receive byte stream. Payload bytes leave through a small FIFO on a
// valid/ready interface tagged with sop/eop/err markers.
module rx_link_framer #(
    parameter int SYNC_COMMAS = 3,
    parameter int LOSS_ERRS   = 4,
    parameter int GOOD_RUN    = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        k_char,
    input  logic [7:0]  data_in,
    input  logic        error,
    output logic        link_up,
    output logic [7:0]  rx_data,
    output logic        rx_sop,
    output logic        rx_eop,
    output logic        rx_err,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        overflow,
    output logic [15:0] frame_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(SYNC_COMMAS + 1);
    localparam int BW = $clog2(LOSS_ERRS + 1);
    localparam int GW = $clog2(GOOD_RUN + 1);

    localparam logic [CW-1:0] SYNC_LIM = CW'(SYNC_COMMAS);
    localparam logic [BW-1:0] LOSS_LIM = BW'(LOSS_ERRS);
    localparam logic [GW-1:0] GOOD_LIM = GW'(GOOD_RUN);

    typedef enum logic [2:0] {
        CLS_COMMA = 3'd0,
        CLS_SOP   = 3'd1,
        CLS_EOP   = 3'd2,
        CLS_DATA  = 3'd3,
        CLS_BAD   = 3'd4
    } cls_e;

    typedef enum logic {
        SYNC_LOSS = 1'b0,
        SYNC_LOCK = 1'b1
    } sync_e;

    typedef enum logic {
        FR_IDLE    = 1'b0,
        FR_PAYLOAD = 1'b1
    } fr_e;

    cls_e           cls_s;

    sync_e          sync_q, sync_d;
    logic           link_q, link_d;
    logic [CW-1:0]  comma_q, comma_d;
    logic [BW-1:0]  bad_q, bad_d;
    logic [GW-1:0]  good_q, good_d;

    fr_e            fr_q, fr_d;
    logic           hold_vld_q, hold_vld_d;
    logic [7:0]     hold_byte_q, hold_byte_d;
    logic           hold_sop_q, hold_sop_d;
    logic           pend_q, pend_d;

    logic           push_s;
    logic [10:0]    push_entry_s;   // {data[7:0], sop, eop, err}
    logic           fcnt_inc_s;

    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic           overflow_q, overflow_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic [10:0]    mem_q [FIFO_DEPTH];

    logic           empty_s, full_s, pop_s, push_ok_s;
    logic [10:0]    head_s;

    // Classify the current character; a decode error overrides everything.
    always_comb begin
        cls_s = CLS_BAD;
        if (error) begin
            cls_s = CLS_BAD;
        end else if (!k_char) begin
            cls_s = CLS_DATA;
        end else begin
            case (data_in)
                8'hBC:   cls_s = CLS_COMMA;
                8'hFB:   cls_s = CLS_SOP;
                8'hFD:   cls_s = CLS_EOP;
                default: cls_s = CLS_BAD;
            endcase
        end
    end

    // Sync FSM next state: comma acquisition, then bad-character credit tracking.
    always_comb begin
        sync_d  = sync_q;
        link_d  = link_q;
        comma_d = comma_q;
        bad_d   = bad_q;
        good_d  = good_q;
        if (enable) begin
            case (sync_q)
                SYNC_LOSS: begin
                    if (cls_s == CLS_COMMA) begin
                        comma_d = comma_q + 1'b1;
                    end else if (cls_s == CLS_BAD) begin
                        comma_d = '0;
                    end else begin
                        comma_d = comma_q;
                    end
                    if (comma_d == SYNC_LIM) begin
                        sync_d  = SYNC_LOCK;
                        link_d  = 1'b1;
                        comma_d = '0;
                        bad_d   = '0;
                        good_d  = '0;
                    end else begin
                        sync_d  = SYNC_LOSS;
                    end
                end
                SYNC_LOCK: begin
                    if (cls_s == CLS_BAD) begin
                        bad_d  = bad_q + 1'b1;
                        good_d = '0;
                        if (bad_d == LOSS_LIM) begin
                            sync_d  = SYNC_LOSS;
                            link_d  = 1'b0;
                            comma_d = '0;
                            bad_d   = '0;
                        end else begin
                            sync_d  = SYNC_LOCK;
                        end
                    end else begin
                        // Saturate while there is no credit to repay.
                        if (good_q < GOOD_LIM) begin
                            good_d = good_q + 1'b1;
                        end else begin
                            good_d = good_q;
                        end
                        if ((good_d == GOOD_LIM) && (bad_q != '0)) begin
                            bad_d  = bad_q - 1'b1;
                            good_d = '0;
                        end else begin
                            bad_d  = bad_q;
                        end
                    end
                end
                default: begin
                    sync_d = SYNC_LOSS;
                    link_d = 1'b0;
                end
            endcase
        end else begin
            sync_d = sync_q;
        end
    end

    // Framer next state: delimiter stripping with a one-byte hold so the last
    // byte of a frame can be tagged with eop (and err on abort).
    always_comb begin
        fr_d         = fr_q;
        hold_vld_d   = hold_vld_q;
        hold_byte_d  = hold_byte_q;
        hold_sop_d   = hold_sop_q;
        pend_d       = pend_q;
        push_s       = 1'b0;
        push_entry_s = {hold_byte_q, hold_sop_q, 1'b0, 1'b0};
        fcnt_inc_s   = 1'b0;
        if (enable && link_q) begin
            case (fr_q)
                FR_IDLE: begin
                    if (cls_s == CLS_SOP) begin
                        fr_d   = FR_PAYLOAD;
                        pend_d = 1'b1;
                    end else begin
                        fr_d   = FR_IDLE;
                    end
                end
                FR_PAYLOAD: begin
                    case (cls_s)
                        CLS_DATA: begin
                            push_s      = hold_vld_q;
                            hold_vld_d  = 1'b1;
                            hold_byte_d = data_in;
                            hold_sop_d  = pend_q;
                            pend_d      = 1'b0;
                        end
                        CLS_COMMA: begin
                            fr_d = FR_PAYLOAD;
                        end
                        CLS_EOP: begin
                            push_s       = hold_vld_q;
                            push_entry_s = {hold_byte_q, hold_sop_q, 1'b1, 1'b0};
                            fcnt_inc_s   = hold_vld_q;
                            fr_d         = FR_IDLE;
                            hold_vld_d   = 1'b0;
                            pend_d       = 1'b0;
                        end
                        default: begin
                            // SOP or BAD inside a frame aborts it.
                            push_s       = hold_vld_q;
                            push_entry_s = {hold_byte_q, hold_sop_q, 1'b1, 1'b1};
                            fr_d         = FR_IDLE;
                            hold_vld_d   = 1'b0;
                            pend_d       = 1'b0;
                        end
                    endcase
                end
                default: begin
                    fr_d       = FR_IDLE;
                    hold_vld_d = 1'b0;
                    pend_d     = 1'b0;
                end
            endcase
        end else if (!link_q && (fr_q == FR_PAYLOAD)) begin
            // Defensive close: a frame can never stay open without link.
            push_s       = hold_vld_q;
            push_entry_s = {hold_byte_q, hold_sop_q, 1'b1, 1'b1};
            fr_d         = FR_IDLE;
            hold_vld_d   = 1'b0;
            pend_d       = 1'b0;
        end else begin
            fr_d = fr_q;
        end
    end

    // FIFO pointer, overflow and frame counter next state.
    always_comb begin
        empty_s   = (wr_ptr_q == rd_ptr_q);
        full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_s     = !empty_s && rx_ready;
        push_ok_s = push_s && (!full_s || pop_s);
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        overflow_d  = overflow_q || (push_s && full_s && !pop_s);
        frame_cnt_d = frame_cnt_q + {15'd0, fcnt_inc_s};
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= SYNC_LOSS;
            link_q      <= 1'b0;
            comma_q     <= '0;
            bad_q       <= '0;
            good_q      <= '0;
            fr_q        <= FR_IDLE;
            hold_vld_q  <= 1'b0;
            hold_byte_q <= 8'h00;
            hold_sop_q  <= 1'b0;
            pend_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= 16'h0000;
        end else begin
            sync_q      <= sync_d;
            link_q      <= link_d;
            comma_q     <= comma_d;
            bad_q       <= bad_d;
            good_q      <= good_d;
            fr_q        <= fr_d;
            hold_vld_q  <= hold_vld_d;
            hold_byte_q <= hold_byte_d;
            hold_sop_q  <= hold_sop_d;
            pend_q      <= pend_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // FIFO storage; the write slot is free even when full if the head pops.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 11'd0;
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_entry_s;
        end else begin
            mem_q[wr_ptr_q[AW-1:0]] <= mem_q[wr_ptr_q[AW-1:0]];
        end
    end

    assign head_s    = mem_q[rd_ptr_q[AW-1:0]];
    assign link_up   = link_q;
    assign rx_valid  = !empty_s;
    assign rx_data   = head_s[10:3];
    assign rx_sop    = head_s[2];
    assign rx_eop    = head_s[1];
    assign rx_err    = head_s[0];
    assign overflow  = overflow_q;
    assign frame_cnt = frame_cnt_q;

endmodule
